// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential restoring divider for signed (Q,N) fixed point with valid/ready handshakes
module qdiv_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         div_by_zero,
  output logic         overflow
);
  localparam int W = N + Q;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] TOP = CW'(W);
  localparam logic [N-1:0] MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic sign, a_neg, ovf;
  logic [N-1:0] abs_a, abs_b, rem, res;
  logic [N:0] rem_sh, diff;
  logic [W-1:0] dvd, quo, quo_next;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign abs_a = a[N-1] ? -a : a;
  assign rem_sh = {rem, dvd[W-1]};
  assign diff = rem_sh - {1'b0, abs_b};
  assign quo_next = {quo[W-2:0], ~diff[N]};
  // magnitude limits are asymmetric: negative results may reach 2^(N-1)
  assign ovf = sign ? (|quo_next[W-1:N] || (quo_next[N-1] && |quo_next[N-2:0])) : |quo_next[W-1:N-1];
  assign res = ovf ? (sign ? MIN : MAX) : (sign ? -quo_next[N-1:0] : quo_next[N-1:0]);
  // first CALC cycle (cnt==TOP) only screens for a zero divisor
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = in_valid ? CALC : IDLE;
    else if (state == CALC) state_next = ((cnt == TOP && abs_b == '0) || cnt == '0) ? DONE : CALC;
    else state_next = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sign <= 1'b0;
      a_neg <= 1'b0;
      abs_b <= '0;
      rem <= '0;
      dvd <= '0;
      quo <= '0;
      c <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        sign <= a[N-1] ^ b[N-1];
        a_neg <= a[N-1];
        abs_b <= b[N-1] ? -b : b;
        dvd <= {abs_a, {Q{1'b0}}};
        rem <= '0;
        quo <= '0;
        cnt <= TOP;
        c <= '0;
        div_by_zero <= 1'b0;
        overflow <= 1'b0;
      end else if (state == CALC) begin
        if (cnt == TOP) begin
          if (abs_b == '0) begin
            c <= a_neg ? MIN : MAX;
            div_by_zero <= 1'b1;
          end
        end else begin
          rem <= diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
          dvd <= dvd << 1;
          quo <= quo_next;
          if (cnt == '0) begin
            c <= res;
            overflow <= ovf;
          end
        end
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: scoreboard bench for qdiv_seq against an integer-arithmetic reference model
module tb_qdiv_seq;
  localparam int Q = 15;
  localparam int N = 32;
  localparam logic [N-1:0] MAX = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MIN = 32'h8000_0000;
  typedef struct {
    logic [N-1:0] c;
    logic dz;
    logic ov;
    int acc;
    int lat;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [N-1:0] a_i = '0, b_i = '0;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [N-1:0] c;
  int total = 0, passed = 0, cyc = 0;
  exp_t sb[$];
  exp_t held;
  logic seen = 0;
  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .div_by_zero(div_by_zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
  endfunction
  function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b, int acc);
    exp_t e;
    longint x = longint'($signed(a));
    longint y = longint'($signed(b));
    longint ax = x < 0 ? -x : x;
    longint ay = y < 0 ? -y : y;
    longint lim = longint'(1) << (N - 1);
    longint mag, r;
    bit neg = (x < 0) != (y < 0);
    e.acc = acc;
    e.dz = 0;
    e.ov = 0;
    if (y == 0) begin
      e.dz = 1;
      e.lat = 1;
      e.c = x < 0 ? MIN : MAX;
      return e;
    end
    e.lat = N + Q + 1;
    mag = (ax << Q) / ay;
    if (!neg && mag > lim - 1) begin e.ov = 1; e.c = MAX; end
    else if (neg && mag > lim) begin e.ov = 1; e.c = MIN; end
    else begin r = neg ? -mag : mag; e.c = r[N-1:0]; end
    return e;
  endfunction
  // scoreboard producer: records every accepted operation with its acceptance cycle
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(a_i, b_i, cyc));
  end
  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          held = sb.pop_front();
          chk("latency", 64'(cyc - held.acc), 64'(held.lat));
          chk("c", 64'(c), 64'(held.c));
          chk("div_by_zero", 64'(div_by_zero), 64'(held.dz));
          chk("overflow", 64'(overflow), 64'(held.ov));
        end
        seen = 1;
      end else begin
        chk("c_stable", 64'({c, div_by_zero, overflow}), 64'({held.c, held.dz, held.ov}));
        chk("in_ready_busy", 64'(in_ready), 0);
      end
      if (out_ready) seen = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(logic [N-1:0] a, logic [N-1:0] b, int hold);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (t >= 200) chk("wait_in_ready_timeout", 1, 0);
    in_valid = 1;
    a_i = a;
    b_i = b;
    tick();
    in_valid = 0;
    a_i = $urandom;
    b_i = $urandom;
    t = 0;
    while (!out_valid && t < 200) begin tick(); t++; end
    if (t >= 200) chk("wait_out_valid_timeout", 1, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("idle_after_handshake", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask
  initial begin
    logic [N-1:0] ra, rb;
    repeat (2) tick();
    rst = 0;
    chk("reset_ports", 64'({in_ready, out_valid, div_by_zero, overflow}), 64'(4'b1000));
    chk("reset_c", 64'(c), 0);
    do_op(32'h0001_8000, 32'h0001_0000, 0);
    do_op(32'h0000_8000, 32'h0001_8000, 1);
    do_op(32'hFFFF_8000, 32'h0001_8000, 0);
    do_op(32'hFFFF_8000, 32'h0002_0000, 2);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op(32'h8000_0000, 32'hFFFF_8000, 0);
    do_op(32'h8000_0000, 32'h0000_8000, 0);
    do_op(32'hFFFF_0000, 32'h0000_0000, 0);
    do_op(32'h0000_0000, 32'h0000_0000, 0);
    do_op(32'h0001_8000, 32'h0001_0000, 10);
    in_valid = 1;
    a_i = 32'h0001_8000;
    b_i = 32'h0001_0000;
    tick();
    in_valid = 0;
    repeat (20) tick();
    rst = 1;
    tick();
    chk("reset_mid_calc", 64'({in_ready, out_valid}), 64'(2'b10));
    rst = 0;
    do_op(32'h0001_8000, 32'h0001_0000, 0);
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 9) == 0) rb = '0;
      do_op(ra, rb, $urandom_range(0, 3));
    end
    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
